// File: rtl/isqrt_rr_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one in-order, pipelined isqrt.
// A tag FIFO remembers who issued each in-flight operand so every result goes back to its owner.
module isqrt_rr_arbiter #(
    parameter int N_REQ        = 3,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [N_REQ*32-1:0]   req_x,
    output logic [N_REQ-1:0]      req_rdy,
    output logic [N_REQ-1:0]      rsp_vld,
    output logic [15:0]           rsp_y,
    output logic                  isqrt_x_vld,
    output logic [31:0]           isqrt_x,
    input  logic                  isqrt_y_vld,
    input  logic [15:0]           isqrt_y,
    output logic                  err_orphan
);
    localparam int TAG_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a request transfers on any posedge where req_vld[i] & req_rdy[i];
    // req_rdy comes from registers only. The isqrt side has no backpressure.
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [31:0]      xbuf_q [N_REQ];
    logic [TAG_W-1:0] last_grant_q;
    logic [TAG_W-1:0] tag_mem_q [MAX_INFLIGHT];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [15:0]      rsp_y_q, rsp_y_d;
    logic             err_q;

    logic [N_REQ-1:0] grant, accept;
    logic [TAG_W-1:0] grant_idx, pop_tag;
    logic             any_found, can_issue, pop;
    int               scan_idx;

    // Scan starts one past the last winner, so a just-served port drops to lowest priority.
    always_comb begin
        grant_idx = '0;
        any_found = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = int'(last_grant_q) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            if (!any_found && pend_q[scan_idx]) begin
                any_found = 1'b1;
                grant_idx = TAG_W'(scan_idx);
            end
        end
    end

    assign can_issue   = any_found && (count_q < CNT_W'(MAX_INFLIGHT));
    assign grant       = can_issue ? (N_REQ'(1) << grant_idx) : '0;
    assign req_rdy     = ~pend_q | grant;
    assign accept      = req_vld & req_rdy;
    assign pend_d      = (pend_q & ~grant) | accept;
    assign isqrt_x_vld = can_issue;
    assign isqrt_x     = can_issue ? xbuf_q[grant_idx] : 32'd0;

    // A result with no outstanding tag is an orphan: dropped and flagged.
    assign pop       = isqrt_y_vld && (count_q != '0);
    assign pop_tag   = tag_mem_q[rd_ptr_q];
    assign rsp_vld_d = pop ? (N_REQ'(1) << pop_tag) : '0;
    assign rsp_y_d   = pop ? isqrt_y : rsp_y_q;
    assign count_d   = count_q + CNT_W'(can_issue) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            last_grant_q <= TAG_W'(N_REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_vld_q    <= '0;
            rsp_y_q      <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < N_REQ; i++) xbuf_q[i] <= '0;
        end else begin
            pend_q    <= pend_d;
            count_q   <= count_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_y_q   <= rsp_y_d;
            err_q     <= err_q | (isqrt_y_vld && (count_q == '0));
            if (can_issue) begin
                last_grant_q <= grant_idx;
                wr_ptr_q     <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i]) xbuf_q[i] <= req_x[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (can_issue) tag_mem_q[wr_ptr_q] <= grant_idx;
    end

    assign rsp_vld    = rsp_vld_q;
    assign rsp_y      = rsp_y_q;
    assign err_orphan = err_q;
endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: directed vectors against a behavioural isqrt pipe with
// adjustable latency, plus per-port expected queues for the streaming cases.
module tb_isqrt_rr_arbiter;
    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_vld = '0;
    logic [N*32-1:0] req_x = '0;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [15:0]     rsp_y;
    logic            isqrt_x_vld;
    logic [31:0]     isqrt_x;
    logic            isqrt_y_vld;
    logic [15:0]     isqrt_y;
    logic            err_orphan;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    isqrt_rr_arbiter #(.N_REQ(N), .MAX_INFLIGHT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_y(rsp_y),
        .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
        .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
        .err_orphan(err_orphan)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sqrt_of(input logic [31:0] x);
        logic [31:0] r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r[15:0];
    endfunction

    // ---------------- behavioural isqrt pipe (shares rst_n) ----------------
    int          lat = 3;
    int          mcyc = 0;
    int          due_q[$];
    logic [15:0] y_q[$];
    logic        m_vld = 1'b0;
    logic [15:0] m_y = '0;
    logic        f_vld = 1'b0;
    logic [15:0] f_y = '0;
    int          out_cnt = 0;
    int          peak = 0;
    logic        prev_x_vld = 1'b0;
    logic        full_en = 1'b0;

    assign isqrt_y_vld = m_vld | f_vld;
    assign isqrt_y     = m_vld ? m_y : f_y;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            due_q.delete();
            y_q.delete();
            m_vld = 1'b0;
            out_cnt = 0;
            prev_x_vld = 1'b0;
        end else begin
            mcyc++;
            // out_cnt tracks what the DUT has consumed at the posedge just passed.
            if (isqrt_y_vld && out_cnt > 0) out_cnt--;
            if (prev_x_vld) out_cnt++;
            if (out_cnt > peak) peak = out_cnt;
            if (full_en && out_cnt == 16) begin
                check("full_no_issue", {31'd0, isqrt_x_vld}, 32'd0);
                check("full_no_rdy", {29'd0, req_rdy & req_vld}, 32'd0);
            end
            prev_x_vld = isqrt_x_vld;
            if (isqrt_x_vld) begin
                due_q.push_back(mcyc + lat);
                y_q.push_back(sqrt_of(isqrt_x));
            end
            m_vld = 1'b0;
            if (due_q.size() > 0 && due_q[0] == mcyc) begin
                void'(due_q.pop_front());
                m_y = y_q.pop_front();
                m_vld = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q [N][$];
    logic        mon_en = 1'b0;
    logic        rot_en = 1'b0;
    int          rot_n = 0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (isqrt_x_vld && rot_en) begin
                check("rot_port", 32'((sqrt_of(isqrt_x) - 16'd1) / 16'd20), 32'(rot_n % 3));
                rot_n++;
            end
            if (rsp_vld != '0) begin
                check("rsp_onehot", 32'($countones(rsp_vld)), 32'd1);
                for (int p = 0; p < N; p++) begin
                    if (rsp_vld[p]) begin
                        if (exp_q[p].size() == 0) check("rsp_extra", 32'd1, 32'd0);
                        else check("rsp_y_port", {16'd0, rsp_y}, {16'd0, exp_q[p].pop_front()});
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        req_vld = '0;
        f_vld = 1'b0;
        mon_en = 1'b0;
        rot_en = 1'b0;
        full_en = 1'b0;
        for (int p = 0; p < N; p++) exp_q[p].delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_stream(input int n, input int l);
        int sent [N];
        int guard;
        logic [31:0] r;
        lat = l;
        guard = 0;
        for (int i = 0; i < N; i++) sent[i] = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        while ((sent[0] < n || sent[1] < n || sent[2] < n) && guard < 2000) begin
            for (int i = 0; i < N; i++) begin
                req_vld[i] = (sent[i] < n);
                r = 32'(20 * i + sent[i] + 1);
                req_x[32*i +: 32] = r * r;
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_vld[i] && req_rdy[i]) begin
                    exp_q[i].push_back(16'(20 * i + sent[i] + 1));
                    sent[i]++;
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        req_vld = '0;
        check("stream_sent", 32'(sent[0] + sent[1] + sent[2]), 32'(3 * n));
        guard = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("drain_left", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rdy"}, {29'd0, req_rdy}, 32'd7);
        check({pfx, "_xvld"}, {31'd0, isqrt_x_vld}, 32'd0);
        check({pfx, "_x"}, isqrt_x, 32'd0);
        check({pfx, "_rspvld"}, {29'd0, rsp_vld}, 32'd0);
        check({pfx, "_rspy"}, {16'd0, rsp_y}, 32'd0);
        check({pfx, "_err"}, {31'd0, err_orphan}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] t2_x [3];
        logic [15:0] t2_y [3];
        t2_x = '{32'd4, 32'd9, 32'd16};
        t2_y = '{16'd2, 16'd3, 16'd4};

        // reset values
        do_reset();
        check_reset_outputs("rst");

        // single request, x=144, latency 3
        lat = 3;
        @(posedge clk); #1;
        req_vld = 3'b001;
        req_x[31:0] = 32'd144;
        @(posedge clk); #1;
        req_vld = '0;
        @(negedge clk);
        check("t1_xvld", {31'd0, isqrt_x_vld}, 32'd1);
        check("t1_x", isqrt_x, 32'd144);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 5) begin
                check("t1_rspvld", {29'd0, rsp_vld}, 32'd1);
                check("t1_rspy", {16'd0, rsp_y}, 32'd12);
            end else begin
                check("t1_rspvld_idle", {29'd0, rsp_vld}, 32'd0);
            end
        end
        check("t1_rspy_hold", {16'd0, rsp_y}, 32'd12);

        // three simultaneous requests from reset
        do_reset();
        lat = 3;
        @(posedge clk); #1;
        req_vld = 3'b111;
        req_x = {32'd16, 32'd9, 32'd4};
        @(posedge clk); #1;
        req_vld = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) check("t2_rdy", {29'd0, req_rdy}, 32'd1);
            if (c <= 3) begin
                check("t2_xvld", {31'd0, isqrt_x_vld}, 32'd1);
                check("t2_x", isqrt_x, t2_x[c-1]);
            end
            if (c == 4) check("t2_xvld_done", {31'd0, isqrt_x_vld}, 32'd0);
            if (c >= 5 && c <= 7) begin
                check("t2_rspvld", {29'd0, rsp_vld}, 32'(1 << (c - 5)));
                check("t2_rspy", {16'd0, rsp_y}, {16'd0, t2_y[c-5]});
            end
            if (c == 8) check("t2_rspvld_idle", {29'd0, rsp_vld}, 32'd0);
        end

        // continuous requests, rotation and per-port ordering
        do_reset();
        rot_en = 1'b1;
        rot_n = 0;
        run_stream(10, 4);
        check("t3_issued", 32'(rot_n), 32'd30);
        check("t3_err", {31'd0, err_orphan}, 32'd0);

        // latency beyond FIFO depth: saturation at 16 outstanding
        do_reset();
        peak = 0;
        full_en = 1'b1;
        run_stream(15, 20);
        full_en = 1'b0;
        check("t4_peak", 32'(peak), 32'd16);
        check("t4_err", {31'd0, err_orphan}, 32'd0);

        // orphan result
        do_reset();
        f_y = 16'h55;
        check("t5_err_before", {31'd0, err_orphan}, 32'd0);
        @(posedge clk); #1;
        f_vld = 1'b1;
        @(posedge clk); #1;
        f_vld = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("t5_rspvld", {29'd0, rsp_vld}, 32'd0);
            check("t5_err", {31'd0, err_orphan}, 32'd1);
        end

        // reset with 5 ops in flight and 2 pending
        do_reset();
        lat = 10;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            req_vld = 3'b001;
            req_x[31:0] = 32'((k + 1) * (k + 1));
            @(posedge clk); #1;
        end
        req_vld = 3'b110;
        req_x[63:32] = 32'd25;
        req_x[95:64] = 32'd36;
        @(posedge clk); #1;
        req_vld = '0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_vld = 3'b100;
        req_x[95:64] = 32'd49;
        @(posedge clk); #1;
        req_vld = '0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("t6_xvld", {31'd0, isqrt_x_vld}, 32'd1);
                check("t6_x", isqrt_x, 32'd49);
            end
            if (c == 11) check("t6_rspvld_early", {29'd0, rsp_vld}, 32'd0);
            if (c == 12) begin
                check("t6_rspvld", {29'd0, rsp_vld}, 32'd4);
                check("t6_rspy", {16'd0, rsp_y}, 32'd7);
            end
            if (c == 13) check("t6_rspvld_once", {29'd0, rsp_vld}, 32'd0);
        end
        check("t6_err", {31'd0, err_orphan}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
